// File: rtl/truth_table_checker.sv
// truth_table_checker: collects (vector, response) pairs from a small
// combinational DUT, builds the observed truth table and compares it against
// an expected table latched at start. Reports coverage, duplicates, mismatch
// count, first failing vector, timeout and a final pass/fail verdict.
module truth_table_checker #(
  parameter int N_IN    = 3,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   exp_table,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN-1:0]        in_vec,
  input  logic                   in_resp,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic                   dup_seen,
  output logic [(1<<N_IN)-1:0]   covered,
  output logic [(1<<N_IN)-1:0]   captured,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic                   first_err_valid,
  output logic [N_IN-1:0]        first_err_vec
);

  localparam int N_ENT  = 1 << N_IN;
  // Idle counter only needs to reach TIMEOUT; keep at least one bit when disabled.
  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_ENT-1:0]   exp_q, exp_d;
  logic [N_ENT-1:0]   covered_q, covered_d;
  logic [N_ENT-1:0]   captured_q, captured_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fev_q, fev_d;
  logic [N_IN-1:0]    fvec_q, fvec_d;
  logic               dup_q, dup_d;
  logic               to_q, to_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               xfer;

  // A sample is only accepted while collecting; start suppresses it below.
  assign xfer = in_valid && (state_q == S_COLLECT);

  // Next-state logic: start wins, then a transfer, then idle/timeout counting.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned
    // (which would infer a latch), and indexed writes below only patch one bit.
    state_d    = state_q;
    exp_d      = exp_q;
    covered_d  = covered_q;
    captured_d = captured_q;
    cnt_d      = cnt_q;
    fev_d      = fev_q;
    fvec_d     = fvec_q;
    dup_d      = dup_q;
    to_d       = to_q;
    idle_d     = idle_q;

    if (start) begin
      state_d    = S_COLLECT;
      exp_d      = exp_table;
      covered_d  = '0;
      captured_d = '0;
      cnt_d      = '0;
      fev_d      = 1'b0;
      fvec_d     = '0;
      dup_d      = 1'b0;
      to_d       = 1'b0;
      idle_d     = '0;
    end else if (xfer) begin
      captured_d[in_vec] = in_resp;
      covered_d[in_vec]  = 1'b1;
      if (covered_q[in_vec]) dup_d = 1'b1;
      if (in_resp != exp_q[in_vec]) begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (!fev_q) begin
          fev_d  = 1'b1;
          fvec_d = in_vec;
        end
      end
      idle_d = '0;
      if (&covered_d) state_d = S_DONE;
    end else if ((state_q == S_COLLECT) && (TIMEOUT != 0)) begin
      idle_d = idle_q + 1'b1;
      if (idle_d == IDLE_W'(TIMEOUT)) begin
        state_d = S_DONE;
        to_d    = 1'b1;
      end
    end
  end

  // State and result registers; everything clears on reset, tables included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tables are small flop arrays, not RAM, so they are reset
      // along with the rest; a mid-run reset must discard all progress.
      state_q    <= S_IDLE;
      exp_q      <= '0;
      covered_q  <= '0;
      captured_q <= '0;
      cnt_q      <= '0;
      fev_q      <= 1'b0;
      fvec_q     <= '0;
      dup_q      <= 1'b0;
      to_q       <= 1'b0;
      idle_q     <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q    <= state_d;
      exp_q      <= exp_d;
      covered_q  <= covered_d;
      captured_q <= captured_d;
      cnt_q      <= cnt_d;
      fev_q      <= fev_d;
      fvec_q     <= fvec_d;
      dup_q      <= dup_d;
      to_q       <= to_d;
      idle_q     <= idle_d;
    end
  end

  assign in_ready        = (state_q == S_COLLECT);
  assign busy            = (state_q == S_COLLECT);
  assign done            = (state_q == S_DONE);
  assign pass            = done && !to_q && (cnt_q == '0) && !dup_q;
  assign timeout         = to_q;
  assign dup_seen        = dup_q;
  assign covered         = covered_q;
  assign captured        = captured_q;
  assign mismatch_cnt    = cnt_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fvec_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: directed scenarios plus random
// sweeps, checked against a model that derives all results from the log of
// accepted transfers.
module tb_truth_table_checker;

  localparam int N_IN    = 3;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 64;
  localparam logic [7:0] MAJ = 8'b1110_1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] exp_table;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_vec;
  logic       in_resp;
  logic       busy, done, pass, timeout, dup_seen;
  logic [7:0] covered, captured;
  logic [3:0] mismatch_cnt;
  logic       first_err_valid;
  logic [2:0] first_err_vec;

  truth_table_checker #(.N_IN(N_IN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_table(exp_table),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .in_resp(in_resp),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .dup_seen(dup_seen),
    .covered(covered), .captured(captured), .mismatch_cnt(mismatch_cnt),
    .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: transfer log plus session flags.
  typedef struct {
    bit [7:0] cov;
    bit [7:0] cap;
    int       mm;
    bit       fev;
    bit [2:0] fvec;
    bit       dup;
    bit       done;
    bit       to;
    bit       pass;
    bit       busy;
  } res_t;

  bit [7:0] m_exp;
  bit       m_started;
  bit       m_to;
  int       q_vec[$];
  bit       q_resp[$];

  function automatic res_t model();
    res_t r;
    r = '{default: 0};
    foreach (q_vec[i]) begin
      if (r.cov[q_vec[i]]) r.dup = 1'b1;
      r.cov[q_vec[i]] = 1'b1;
      r.cap[q_vec[i]] = q_resp[i];
      if (q_resp[i] != m_exp[q_vec[i]]) begin
        if (!r.fev) begin
          r.fev  = 1'b1;
          r.fvec = 3'(q_vec[i]);
        end
        r.mm++;
      end
    end
    if (r.mm > 15) r.mm = 15;
    r.to   = m_to;
    r.done = m_started && (r.cov == 8'hFF || m_to);
    r.busy = m_started && !r.done;
    r.pass = r.done && !r.to && r.mm == 0 && !r.dup;
    return r;
  endfunction

  task automatic check_all(input string tag);
    res_t r;
    r = model();
    check({tag, ".covered"},  covered,         r.cov);
    check({tag, ".captured"}, captured,        r.cap);
    check({tag, ".mm_cnt"},   mismatch_cnt,    r.mm);
    check({tag, ".fev"},      first_err_valid, r.fev);
    check({tag, ".fvec"},     first_err_vec,   r.fvec);
    check({tag, ".dup"},      dup_seen,        r.dup);
    check({tag, ".done"},     done,            r.done);
    check({tag, ".busy"},     busy,            r.busy);
    check({tag, ".ready"},    in_ready,        r.busy);
    check({tag, ".timeout"},  timeout,         r.to);
    check({tag, ".pass"},     pass,            r.pass);
  endtask

  // All tasks are entered and left on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    m_exp = '0; m_started = 1'b0; m_to = 1'b0;
    q_vec.delete(); q_resp.delete();
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [7:0] e, input bit with_valid);
    start     = 1'b1;
    exp_table = e;
    in_valid  = with_valid;
    in_vec    = 3'($urandom);
    in_resp   = 1'($urandom);
    @(negedge clk);
    start     = 1'b0;
    in_valid  = 1'b0;
    exp_table = 8'($urandom);
    m_exp = e; m_started = 1'b1; m_to = 1'b0;
    q_vec.delete(); q_resp.delete();
  endtask

  task automatic send(input logic [2:0] v, input logic r);
    bit acc;
    acc      = model().busy;
    in_valid = 1'b1;
    in_vec   = v;
    in_resp  = r;
    @(negedge clk);
    in_valid = 1'b0;
    if (acc) begin
      q_vec.push_back(int'(v));
      q_resp.push_back(r);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    logic [2:0] v;
    logic [2:0] order [8];
    int n;
    start = 1'b0; in_valid = 1'b0; in_vec = '0; in_resp = 1'b0; exp_table = '0;
    rst_n = 1'b1;
    @(negedge clk);
    do_reset();

    // in_valid while idle has no effect
    send(3'd5, 1'b1);
    check_all("idle_ignore");

    // 1: majority, ascending, correct
    pulse_start(MAJ, 1'b1);
    check_all("t1.start");
    for (int i = 0; i < 8; i++) begin
      e = MAJ;
      send(3'(i), e[i]);
      check_all($sformatf("t1.v%0d", i));
    end
    check("t1.done_const", done, 1'b1);
    check("t1.pass_const", pass, 1'b1);
    check("t1.cap_const", captured, 8'hE8);
    check("t1.cov_const", covered, 8'hFF);

    // in_valid while done has no effect
    send(3'd2, 1'b1);
    send(3'd6, 1'b0);
    check_all("done_ignore");

    // 2: vectors 2 and 6 inverted
    pulse_start(MAJ, 1'b0);
    for (int i = 0; i < 8; i++) begin
      e = MAJ;
      send(3'(i), e[i] ^ (i == 2 || i == 6));
      check_all($sformatf("t2.v%0d", i));
    end
    check("t2.mm_const", mismatch_cnt, 4'd2);
    check("t2.fvec_const", first_err_vec, 3'd2);
    check("t2.fev_const", first_err_valid, 1'b1);
    check("t2.cap_const", captured, 8'hAC);
    check("t2.pass_const", pass, 1'b0);

    // 3: shuffled order with 3 idle cycles between transfers
    order = '{3'd7, 3'd0, 3'd5, 3'd2, 3'd4, 3'd1, 3'd6, 3'd3};
    pulse_start(MAJ, 1'b0);
    for (int i = 0; i < 8; i++) begin
      e = MAJ;
      send(order[i], e[order[i]]);
      check_all($sformatf("t3.i%0d", i));
      if (i < 7) idle(3);
    end
    check("t3.pass_const", pass, 1'b1);
    check("t3.to_const", timeout, 1'b0);

    // 4: partial sweep then timeout
    pulse_start(MAJ, 1'b0);
    for (int i = 0; i < 5; i++) begin
      e = MAJ;
      send(3'(i), e[i]);
    end
    idle(62);
    check_all("t4.before_to");
    idle(2);
    m_to = 1'b1;
    check_all("t4.after_to");
    check("t4.cov_const", covered, 8'h1F);
    check("t4.to_const", timeout, 1'b1);

    // 5: vector 3 twice, second wrong
    pulse_start(MAJ, 1'b0);
    send(3'd3, 1'b1);
    send(3'd3, 1'b0);
    check_all("t5.dup");
    for (int i = 0; i < 8; i++) begin
      e = MAJ;
      if (i != 3) send(3'(i), e[i]);
    end
    check_all("t5.end");
    check("t5.cap3", captured[3], 1'b0);
    check("t5.mm_const", mismatch_cnt, 4'd1);

    // saturation of the mismatch counter
    pulse_start(MAJ, 1'b0);
    for (int i = 0; i < 20; i++) send(3'd0, 1'b1);
    check_all("sat.mid");
    for (int i = 1; i < 8; i++) begin
      e = MAJ;
      send(3'(i), e[i]);
    end
    check_all("sat.end");
    check("sat.mm_const", mismatch_cnt, 4'd15);

    // 6: reset mid-collect, then a full sweep; start from DONE clears
    pulse_start(MAJ, 1'b0);
    for (int i = 0; i < 4; i++) begin
      e = MAJ;
      send(3'(i), e[i]);
    end
    do_reset();
    check_all("t6.after_rst");
    pulse_start(MAJ, 1'b0);
    for (int i = 0; i < 8; i++) begin
      e = MAJ;
      send(3'(i), e[i]);
    end
    check_all("t6.end");
    check("t6.pass_const", pass, 1'b1);
    pulse_start(8'h5A, 1'b1);
    check_all("t6.restart");
    check("t6.cov_clear", covered, 8'h00);

    // random sweeps with errors, duplicates, gaps and random start overlap
    for (int it = 0; it < 20; it++) begin
      e = 8'($urandom);
      pulse_start(e, 1'($urandom));
      n = 0;
      while (!model().done && n < 200) begin
        v = 3'($urandom_range(0, 7));
        send(v, e[v] ^ ($urandom_range(0, 7) == 0));
        check_all($sformatf("rnd%0d.s%0d", it, n));
        idle($urandom_range(0, 3));
        n++;
      end
      check($sformatf("rnd%0d.done", it), done, 1'b1);
      send(3'($urandom), 1'($urandom));
      check_all($sformatf("rnd%0d.post", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
